// File: rtl/ps2_rx_fifo.sv
// PS/2 receive front end: synchronises the raw pins, deframes 11-bit frames with
// start/parity/stop checks, and queues good scan-code bytes in a small FIFO.
module ps2_rx_fifo #(
    parameter int ADDR_W         = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    input  logic              nextdata_n,
    output logic [7:0]        data,
    output logic              ready,
    output logic              overflow,
    output logic              frame_err,
    output logic [ADDR_W:0]   level
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [2:0]        clk_sync;
    logic [1:0]        data_sync;
    logic [3:0]        bit_cnt;
    logic [9:0]        frame_buf;
    logic [TW-1:0]     to_cnt;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr;

    logic fall;
    logic stop_fall;
    logic frame_ok;
    logic push;
    logic pop;
    logic full;
    logic wr_en;

    assign fall      = (clk_sync[2:1] == 2'b10);
    assign stop_fall = fall && (bit_cnt == 4'd10);
    // The stop bit is taken straight from the synchroniser; it never enters frame_buf.
    assign frame_ok  = !frame_buf[0] && data_sync[1] && (^frame_buf[9:1]);
    assign push      = stop_fall && frame_ok;
    assign ready     = (level != '0);
    assign pop       = !nextdata_n && ready;
    assign full      = (level == (ADDR_W+1)'(DEPTH));
    assign wr_en     = push && (!full || pop);
    assign data      = ready ? mem[r_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
            bit_cnt   <= 4'd0;
            frame_buf <= 10'd0;
            to_cnt    <= '0;
            frame_err <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            if (fall) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                    if (!frame_ok) frame_err <= 1'b1;
                end else begin
                    frame_buf[bit_cnt] <= data_sync[1];
                    bit_cnt            <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt == 4'd0) begin
                to_cnt <= '0;
            end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                // Keyboard stalled mid-frame: abandon it so the next start bit realigns.
                bit_cnt   <= 4'd0;
                to_cnt    <= '0;
                frame_err <= 1'b1;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr    <= '0;
            w_ptr    <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) w_ptr <= w_ptr + ADDR_W'(1);
            if (pop)   r_ptr <= r_ptr + ADDR_W'(1);
            case ({wr_en, pop})
                2'b10:   level <= level + (ADDR_W+1)'(1);
                2'b01:   level <= level - (ADDR_W+1)'(1);
                default: level <= level;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[w_ptr] <= frame_buf[8:1];
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: drives PS/2 frames on the pins and compares the FIFO
// outputs against a queue-based reference model.
module tb_ps2_rx_fifo;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam int TO     = 200;
    localparam int HALF   = 40;

    logic              clk = 1'b0;
    logic              reset;
    logic              ps2_clk;
    logic              ps2_data;
    logic              nextdata_n;
    logic [7:0]        data;
    logic              ready;
    logic              overflow;
    logic              frame_err;
    logic [ADDR_W:0]   level;

    ps2_rx_fifo #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nextdata_n), .data(data), .ready(ready),
        .overflow(overflow), .frame_err(frame_err), .level(level)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model
    logic [7:0] exp_q[$];
    logic       m_ovf;
    logic       m_ferr;

    typedef struct {
        logic [7:0] code;
        int         fault;
        logic [3:0] exp_level;
        logic       exp_ferr;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // fault: 0 good, 1 parity flipped, 2 stop=0, 3 start=1
    function automatic logic [10:0] mk_frame(input logic [7:0] d, input int fault);
        logic [10:0] f;
        f = {1'b1, ~^d, d, 1'b0};
        if (fault == 1) f[9] = ~f[9];
        if (fault == 2) f[10] = 1'b0;
        if (fault == 3) f[0] = 1'b1;
        return f;
    endfunction

    task automatic model_frame(input logic [7:0] d, input int fault);
        if (fault != 0) m_ferr = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else m_ovf = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int fault);
        send_bits(mk_frame(d, fault), 11);
        repeat (8) @(negedge clk);
        model_frame(d, fault);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_level"}, 32'(level), 32'(exp_q.size()));
        chk({tag, "_ready"}, 32'(ready), 32'(exp_q.size() != 0));
        chk({tag, "_data"}, 32'(data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
    endtask

    task automatic pop_one(input string tag);
        if (exp_q.size() != 0) chk({tag, "_pop_data"}, 32'(data), 32'(exp_q[0]));
        @(negedge clk) nextdata_n = 1'b0;
        @(negedge clk) nextdata_n = 1'b1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        chk({tag, "_pop_level"}, 32'(level), 32'(exp_q.size()));
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        exp_q.delete();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
    endtask

    initial begin
        logic [10:0] f;
        logic [7:0]  d;
        int          r;
        int          fault;

        tbl[0] = '{8'h1C, 0, 4'd1, 1'b0};
        tbl[1] = '{8'hF0, 0, 4'd2, 1'b0};
        tbl[2] = '{8'h45, 1, 4'd2, 1'b1};
        tbl[3] = '{8'h45, 2, 4'd2, 1'b1};
        tbl[4] = '{8'h16, 0, 4'd3, 1'b1};
        tbl[5] = '{8'h33, 3, 4'd3, 1'b1};
        tbl[6] = '{8'h5A, 0, 4'd4, 1'b1};

        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
        exp_q.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_state("reset");

        // single 0x1C frame with exact push latency
        f = mk_frame(8'h1C, 0);
        send_bits(f, 10);
        @(negedge clk) ps2_data = f[10];
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        chk("t1_not_early", 32'(ready), 32'h0);
        @(negedge clk);
        chk("t1_ready", 32'(ready), 32'h1);
        chk("t1_data", 32'(data), 32'h1C);
        chk("t1_level", 32'(level), 32'h1);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        exp_q.push_back(8'h1C);
        pop_one("t1");
        check_state("t1_empty");
        pop_one("t1_empty_pop");
        check_state("t1_after_empty_pop");

        // table: good and corrupted frames
        do_reset();
        foreach (tbl[i]) begin
            send_frame(tbl[i].code, tbl[i].fault);
            chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].exp_level));
            chk($sformatf("tbl%0d_ferr", i), 32'(frame_err), 32'(tbl[i].exp_ferr));
            check_state($sformatf("tbl%0d", i));
        end
        repeat (4) pop_one("tbl_drain");
        check_state("tbl_drained");

        // overflow: nine bytes into eight slots
        do_reset();
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0);
        check_state("ovf_full");
        repeat (8) pop_one("ovf_drain");
        check_state("ovf_drained");

        // timeout in the middle of a frame
        do_reset();
        send_bits(mk_frame(8'h77, 0), 5);
        repeat (250) @(negedge clk);
        m_ferr = 1'b1;
        send_frame(8'h32, 0);
        check_state("timeout");
        chk("timeout_data", 32'(data), 32'h32);

        // full FIFO with push and pop on the same edge
        do_reset();
        for (int i = 0; i < 8; i++) send_frame(8'hA0 + 8'(i), 0);
        check_state("pp_full");
        f = mk_frame(8'hB8, 0);
        send_bits(f, 10);
        @(negedge clk) ps2_data = f[10];
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        nextdata_n = 1'b0;
        @(negedge clk) nextdata_n = 1'b1;
        void'(exp_q.pop_front());
        exp_q.push_back(8'hB8);
        chk("pp_level", 32'(level), 32'h8);
        chk("pp_ovf", 32'(overflow), 32'h0);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (8) @(negedge clk);
        check_state("pp_after");

        // reset in the middle of a frame
        send_bits(mk_frame(8'h55, 0), 5);
        do_reset();
        check_state("mid_reset");
        send_frame(8'h29, 0);
        check_state("post_reset");

        // randomized frames and pops
        do_reset();
        for (int n = 0; n < 16; n++) begin
            d = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 7);
            fault = (r < 5) ? 0 : r - 4;
            send_frame(d, fault);
            check_state($sformatf("rnd%0d", n));
            r = $urandom_range(0, 2);
            for (int k = 0; k < r; k++) pop_one($sformatf("rnd%0d", n));
        end
        check_state("rnd_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
